rotate_share_scheduler: RTL and testbench

- Shares one combinational WIDTH-bit rotator (left/right, variable amount) among N requesters.
- Each requester has an independent valid/ready request channel. The block grants round-robin, registers the rotated result, and presents it on one valid/ready output channel tagged with the requester id.
- It sits between the lab's operand sources and any downstream consumer of rotated words.

---
 rtl/rotate_share_scheduler_pkg.sv | 19 +
 rtl/rotate_share_scheduler_if.sv | 34 +++
 rtl/rotate_share_scheduler_rot_unit.sv | 33 +++
 rtl/rotate_share_scheduler.sv | 125 ++++++++++++
 tb/tb_rotate_share_scheduler.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/rotate_share_scheduler_pkg.sv
// Shared types and constants for the rotate-share scheduler.
//   rot_dir_t      : rotate direction encoding (0 = left, 1 = right)
//   sched_state_t  : result-register occupancy state
//   GRANT_CNT_W    : width of the saturating accepted-request counter
package rot_sched_pkg;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } rot_dir_t;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } sched_state_t;

  localparam int GRANT_CNT_W = 16;

endpackage

// File: rtl/rotate_share_scheduler_if.sv
// Bundle of the request channels, the result channel and the grant counter.
//   master : requesters + consumer side (drives requests and out_ready)
//   slave  : scheduler side (drives req_ready, result and grant_cnt)
// Requester i occupies req_data[i*WIDTH +: WIDTH] and req_amt[i*AMT_W +: AMT_W].
interface rotate_share_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int AMT_W = $clog2(WIDTH),
  parameter int ID_W  = $clog2(N)
);
  import rot_sched_pkg::*;

  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_ready;
  logic [N*WIDTH-1:0]     req_data;
  logic [N*AMT_W-1:0]     req_amt;
  logic [N-1:0]           req_dir;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [ID_W-1:0]        out_id;
  logic [GRANT_CNT_W-1:0] grant_cnt;

  modport master (
    output req_valid, req_data, req_amt, req_dir, out_ready,
    input  req_ready, out_valid, out_data, out_id, grant_cnt
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_dir, out_ready,
    output req_ready, out_valid, out_data, out_id, grant_cnt
  );

endinterface

// File: rtl/rotate_share_scheduler_rot_unit.sv
// Combinational barrel rotator.
//   data_i   : operand word
//   amt_i    : rotate amount
//   dir_i    : DIR_LEFT or DIR_RIGHT
//   result_o : rotated word (lossless; amt 0 passes data through)
module rot_unit
  import rot_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  input  rot_dir_t         dir_i,
  output logic [WIDTH-1:0] result_o
);

  // WIDTH is a power of two, so the modulo reduces to masking the index.
  always_comb begin
    logic [AMT_W-1:0] src;
    result_o = '0;
    src      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (dir_i == DIR_LEFT) begin
        src = AMT_W'(i) - amt_i;
      end else begin
        src = AMT_W'(i) + amt_i;
      end
      result_o[i] = data_i[src];
    end
  end

endmodule

// File: rtl/rotate_share_scheduler.sv
// Round-robin scheduler sharing one rotator among N requesters.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : request channels in, registered result channel out, grant counter
// The result register is a one-entry buffer that can be drained and refilled
// on the same edge, giving one result per cycle.
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | result register empty, out_valid = 0
// ST_FULL  | result register holds a result, out_valid = 1
module rotate_share_scheduler
  import rot_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int AMT_W = $clog2(WIDTH),
  localparam int ID_W  = $clog2(N)
) (
  input  logic clk,
  input  logic rst_n,
  rotate_share_scheduler_if.slave bus
);

  sched_state_t           state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic [ID_W-1:0]        out_id_q, out_id_d;
  logic [GRANT_CNT_W-1:0] grant_cnt_q, grant_cnt_d;

  logic                   win_found;
  logic [ID_W-1:0]        win_idx;
  logic                   can_accept;
  logic                   xfer;
  logic [N-1:0]           req_ready;
  logic [WIDTH-1:0]       sel_data;
  logic [AMT_W-1:0]       sel_amt;
  rot_dir_t               sel_dir;
  logic [WIDTH-1:0]       rot_result;

  // First valid requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr_q) + k) % N;
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(idx);
      end
    end
  end

  // rst_n gates acceptance so a request seen during reset is never taken.
  assign can_accept = rst_n && ((state_q == ST_EMPTY) || bus.out_ready);
  assign xfer       = win_found && can_accept;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  assign sel_data = bus.req_data[int'(win_idx)*WIDTH +: WIDTH];
  assign sel_amt  = bus.req_amt[int'(win_idx)*AMT_W +: AMT_W];
  assign sel_dir  = rot_dir_t'(bus.req_dir[win_idx]);

  rot_unit #(
    .WIDTH (WIDTH)
  ) u_rot (
    .data_i   (sel_data),
    .amt_i    (sel_amt),
    .dir_i    (sel_dir),
    .result_o (rot_result)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    grant_cnt_d = grant_cnt_q;

    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (!xfer && bus.out_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (xfer) begin
      out_data_d = rot_result;
      out_id_d   = win_idx;
      rr_ptr_d   = (int'(win_idx) == N-1) ? '0 : win_idx + ID_W'(1);
      if (grant_cnt_q != '1) begin
        grant_cnt_d = grant_cnt_q + GRANT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      grant_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_rotate_share_scheduler.sv
module tb_rotate_share_scheduler;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int AW = 3;

  logic clk;
  logic rst_n;
  logic mon_en;
  int   total;
  int   bad;

  rotate_share_scheduler_if #(.WIDTH(W), .N(N)) bus ();

  rotate_share_scheduler #(.WIDTH(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rotate: plain integer shift-and-or on a WIDTH-bit word.
  function automatic int mrot(input int d, input int a, input bit right);
    int mask, sh;
    mask = (1 << W) - 1;
    sh   = right ? (W - a) % W : a;
    return ((d << sh) | (d >> (W - sh))) & mask;
  endfunction

  // Transaction-level model: one held result plus a round-robin pointer.
  bit      m_valid;
  int      m_data;
  int      m_id;
  int      m_rr;
  int      m_cnt;

  always @(negedge clk) begin
    if (mon_en) begin
      int win;
      bit can;
      logic [N-1:0] exp_ready;
      win = -1;
      exp_ready = '0;
      can = rst_n && (!m_valid || bus.out_ready);
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (win < 0 && bus.req_valid[idx]) win = idx;
      end
      if (win >= 0 && can) exp_ready[win] = 1'b1;

      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("grant_cnt", 32'(bus.grant_cnt), 32'(m_cnt));
      if (m_valid) begin
        chk("out_data", 32'(bus.out_data), 32'(m_data));
        chk("out_id", 32'(bus.out_id), 32'(m_id));
      end

      if (!rst_n) begin
        m_valid = 0; m_data = 0; m_id = 0; m_rr = 0; m_cnt = 0;
      end else if (win >= 0 && can) begin
        m_valid = 1;
        m_data  = mrot(int'(bus.req_data[win*W +: W]), int'(bus.req_amt[win*AW +: AW]),
                       bus.req_dir[win]);
        m_id    = win;
        m_rr    = (win + 1) % N;
        if (m_cnt < 65535) m_cnt++;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input int a, input bit dir);
    bus.req_data[i*W +: W]  = d;
    bus.req_amt[i*AW +: AW] = AW'(a);
    bus.req_dir[i]          = dir;
  endtask

  initial begin
    total = 0; bad = 0; mon_en = 0;
    m_valid = 0; m_data = 0; m_id = 0; m_rr = 0; m_cnt = 0;
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_amt = '0; bus.req_dir = '0;
    bus.out_ready = 1'b1;

    // model pins
    chk("model_l5", 32'(mrot(8'h66, 5, 0)), 32'h0CC);
    chk("model_r5", 32'(mrot(8'h66, 5, 1)), 32'h033);
    chk("model_r0", 32'(mrot(8'hC7, 0, 1)), 32'h0C7);

    step();
    mon_en = 1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_id", 32'(bus.out_id), 0);
    chk("rst_cnt", 32'(bus.grant_cnt), 0);
    rst_n = 1'b1;

    // single requester, left then right
    set_req(0, 8'h66, 5, 0);
    bus.req_valid = 4'b0001;
    step();
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_data", 32'(bus.out_data), 32'h0CC);
    chk("t1_id", 32'(bus.out_id), 0);
    bus.req_dir[0] = 1'b1;
    step();
    chk("t1r_data", 32'(bus.out_data), 32'h033);
    bus.req_valid = '0;
    step();
    chk("t1_drain", 32'(bus.out_valid), 0);
    chk("t1_cnt", 32'(bus.grant_cnt), 2);

    // two requesters alternating at full throughput
    set_req(1, 8'h23, 7, 0);
    set_req(2, 8'hC7, 2, 1);
    bus.req_valid = 4'b0110;
    for (int r = 0; r < 4; r++) begin
      step();
      chk("t2_id", 32'(bus.out_id), (r % 2 == 0) ? 1 : 2);
      chk("t2_data", 32'(bus.out_data), (r % 2 == 0) ? 32'h091 : 32'h0F1);
      chk("t2_cnt", 32'(bus.grant_cnt), 3 + r);
    end
    bus.req_valid = '0;
    step();

    // wrap: grant to 3 (passthrough left) moves the pointer back to 0
    set_req(3, 8'hC7, 0, 0);
    bus.req_valid = 4'b1000;
    step();
    chk("wrap_id", 32'(bus.out_id), 3);
    chk("wrap_pass", 32'(bus.out_data), 32'h0C7);
    bus.req_valid = '0;
    step();

    // backpressure with all four valid
    set_req(0, 8'h66, 5, 0);
    set_req(3, 8'hC7, 0, 1);
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b0;
    step();
    chk("bp_first_id", 32'(bus.out_id), 0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_id", 32'(bus.out_id), 0);
      chk("bp_hold_data", 32'(bus.out_data), 32'h0CC);
      chk("bp_ready", 32'(bus.req_ready), 0);
    end
    bus.out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      step();
      chk("bp_order", 32'(bus.out_id), (g + 1) % N);
    end
    chk("bp_pass_r", 32'(g_last_data()), 32'h0CC);

    // reset while FULL, with requests still pending
    rst_n = 1'b0;
    step();
    chk("mrst_valid", 32'(bus.out_valid), 0);
    chk("mrst_cnt", 32'(bus.grant_cnt), 0);
    rst_n = 1'b1;
    bus.req_valid = 4'b1100;
    step();
    chk("mrst_first", 32'(bus.out_id), 2);
    chk("mrst_data", 32'(bus.out_data), 32'h0F1);

    // saturation
    bus.req_valid = 4'b0001;
    for (int s = 0; s < 65540; s++) step();
    chk("sat_cnt", 32'(bus.grant_cnt), 32'hFFFF);
    step();
    chk("sat_hold", 32'(bus.grant_cnt), 32'hFFFF);
    bus.req_valid = '0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [7:0] g_last_data();
    return bus.out_data;
  endfunction

endmodule
